// File: rtl/dvs_line_dma_sched_if.sv
// Command/completion channel between the line scheduler and the PS CDMA.
// The scheduler is the master (drives the command); the DMA side is the slave.
interface dvs_line_dma_sched_if;
  logic        dma_cmd_valid;
  logic        dma_cmd_ready;
  logic        dma_cmd_dir;
  logic [31:0] dma_cmd_addr;
  logic [15:0] dma_cmd_len;
  logic        dma_done;
  logic        dma_err;

  modport master (
    output dma_cmd_valid, dma_cmd_dir, dma_cmd_addr, dma_cmd_len,
    input  dma_cmd_ready, dma_done, dma_err
  );

  modport slave (
    input  dma_cmd_valid, dma_cmd_dir, dma_cmd_addr, dma_cmd_len,
    output dma_cmd_ready, dma_done, dma_err
  );
endinterface

// File: rtl/dvs_line_dma_sched.sv
// Line DMA scheduler: one CDMA command at a time, write before read; command valid 1 cycle after a request.
// Command held stable until dma_cmd_ready; requests queue one-deep per type while the DMA is busy.
module dvs_line_dma_sched #(
  parameter logic [31:0] BASE_A     = 32'h1000_0000,
  parameter logic [31:0] BASE_B     = 32'h1002_0000,
  parameter int          LINE_BYTES = 256,
  parameter int          NUM_LINES  = 128
) (
  input  logic                        pclk,
  input  logic                        reset,
  input  logic                        new_frame,
  input  logic                        rd_line_req,
  input  logic                        wr_line_req,
  dvs_line_dma_sched_if.master        dma,
  output logic                        buf_sel,
  output logic [7:0]                  rd_line,
  output logic [7:0]                  wr_line,
  output logic                        busy,
  output logic                        overrun,
  output logic                        dma_fault
);

  localparam logic [7:0]  LAST_LINE = 8'(NUM_LINES);
  localparam logic [31:0] LBYTES    = 32'(LINE_BYTES);
  localparam logic [15:0] LEN       = 16'(LINE_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t      state, state_nx;
  logic        new_frame_q, frame_pend;
  logic        rd_pend, wr_pend;
  logic        cmd_dir;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;

  logic        frame_edge, frame_apply;
  logic        load_rd, load_wr, xfer_ok, xfer_err;
  logic        accept_rd, accept_wr, rd_blocked, wr_blocked;
  logic [31:0] rd_addr, wr_addr;

  assign frame_edge = new_frame & ~new_frame_q;

  // Pulses at or after a frame edge belong to the new frame, whose counters restart at 0.
  assign accept_rd = rd_line_req & (frame_edge | frame_pend | (rd_line != LAST_LINE));
  assign accept_wr = wr_line_req & (frame_edge | frame_pend | (wr_line != LAST_LINE));

  assign rd_blocked = rd_pend & ~load_rd & ~frame_edge;
  assign wr_blocked = wr_pend & ~load_wr & ~frame_edge;

  assign rd_addr = (buf_sel ? BASE_B : BASE_A) + ({24'd0, rd_line} * LBYTES);
  assign wr_addr = (buf_sel ? BASE_A : BASE_B) + ({24'd0, wr_line} * LBYTES);

  assign dma.dma_cmd_valid = (state == ISSUE);
  assign dma.dma_cmd_dir   = cmd_dir;
  assign dma.dma_cmd_addr  = cmd_addr;
  assign dma.dma_cmd_len   = cmd_len;
  assign busy              = (state != IDLE);

  always_comb begin
    state_nx    = state;
    frame_apply = 1'b0;
    load_rd     = 1'b0;
    load_wr     = 1'b0;
    xfer_ok     = 1'b0;
    xfer_err    = 1'b0;
    case (state)
      IDLE: begin
        // Write first so the result line leaves BRAM before the next reference lands on it.
        if (frame_pend) begin
          frame_apply = 1'b1;
        end else if (wr_pend) begin
          load_wr  = 1'b1;
          state_nx = ISSUE;
        end else if (rd_pend) begin
          load_rd  = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (dma.dma_cmd_ready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dma.dma_err) begin
          xfer_err = 1'b1;
          state_nx = IDLE;
        end else if (dma.dma_done) begin
          xfer_ok  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      new_frame_q <= 1'b0;
      frame_pend  <= 1'b0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      cmd_dir     <= 1'b0;
      cmd_addr    <= 32'd0;
      cmd_len     <= 16'd0;
      buf_sel     <= 1'b0;
      rd_line     <= 8'd0;
      wr_line     <= 8'd0;
      overrun     <= 1'b0;
      dma_fault   <= 1'b0;
    end else begin
      state       <= state_nx;
      new_frame_q <= new_frame;

      if (accept_rd)                rd_pend <= 1'b1;
      else if (frame_edge | load_rd) rd_pend <= 1'b0;
      if (accept_wr)                wr_pend <= 1'b1;
      else if (frame_edge | load_wr) wr_pend <= 1'b0;

      if ((accept_rd & rd_blocked) | (accept_wr & wr_blocked)) overrun <= 1'b1;

      if (load_wr) begin
        cmd_dir  <= 1'b1;
        cmd_addr <= wr_addr;
        cmd_len  <= LEN;
      end else if (load_rd) begin
        cmd_dir  <= 1'b0;
        cmd_addr <= rd_addr;
        cmd_len  <= LEN;
      end

      if (xfer_err) dma_fault <= 1'b1;
      if (xfer_ok) begin
        if (cmd_dir) wr_line <= wr_line + 8'd1;
        else         rd_line <= rd_line + 8'd1;
      end

      if (frame_apply) begin
        rd_line <= 8'd0;
        wr_line <= 8'd0;
        buf_sel <= ~buf_sel;
      end

      if (frame_edge)       frame_pend <= 1'b1;
      else if (frame_apply) frame_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dvs_line_dma_sched.sv
// Directed bench for dvs_line_dma_sched with a transaction-level reference model.
module tb_dvs_line_dma_sched;
  localparam logic [31:0] BASE_A     = 32'h1000_0000;
  localparam logic [31:0] BASE_B     = 32'h1002_0000;
  localparam int          LINE_BYTES = 256;
  localparam int          NUM_LINES  = 128;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       new_frame = 1'b0;
  logic       rd_line_req = 1'b0;
  logic       wr_line_req = 1'b0;
  logic       buf_sel, busy, overrun, dma_fault;
  logic [7:0] rd_line, wr_line;

  dvs_line_dma_sched_if dma();

  dvs_line_dma_sched #(
    .BASE_A(BASE_A), .BASE_B(BASE_B), .LINE_BYTES(LINE_BYTES), .NUM_LINES(NUM_LINES)
  ) dut (
    .pclk(pclk), .reset(reset), .new_frame(new_frame),
    .rd_line_req(rd_line_req), .wr_line_req(wr_line_req),
    .dma(dma),
    .buf_sel(buf_sel), .rd_line(rd_line), .wr_line(wr_line),
    .busy(busy), .overrun(overrun), .dma_fault(dma_fault)
  );

  always #5 pclk = ~pclk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected command directions are queued by the stimulus;
  // addresses, counters, buffer select and fault come from the line/frame rules.
  bit   exp_dir[$];
  int   m_rd, m_wr;
  bit   m_buf, m_fault, m_acc, m_acc_dir, m_infl, m_fpend, m_nf_q;
  logic [31:0] e_addr;

  always @(negedge pclk) begin
    chk("dma_fault", dma_fault, m_fault);
    if (reset) begin
      m_rd = 0; m_wr = 0; m_buf = 0; m_fault = 0;
      m_acc = 0; m_infl = 0; m_fpend = 0; m_nf_q = 0;
      exp_dir.delete();
    end else begin
      if (m_acc && (dma.dma_err || dma.dma_done)) begin
        if (dma.dma_err)    m_fault = 1;
        else if (m_acc_dir) m_wr++;
        else                m_rd++;
        m_acc  = 0;
        m_infl = 0;
      end
      if (dma.dma_cmd_valid) begin
        m_infl = 1;
        if (exp_dir.size() == 0) begin
          chk("unexpected_cmd", 32'd1, 32'd0);
        end else begin
          e_addr = exp_dir[0] ? ((m_buf ? BASE_A : BASE_B) + 32'(m_wr) * LINE_BYTES)
                              : ((m_buf ? BASE_B : BASE_A) + 32'(m_rd) * LINE_BYTES);
          chk("cmd_dir",  dma.dma_cmd_dir,  exp_dir[0]);
          chk("cmd_addr", dma.dma_cmd_addr, e_addr);
          chk("cmd_len",  dma.dma_cmd_len,  LINE_BYTES);
          chk("buf_sel",  buf_sel,          m_buf);
          chk("rd_line",  rd_line,          m_rd);
          chk("wr_line",  wr_line,          m_wr);
          if (dma.dma_cmd_ready) begin
            m_acc     = 1;
            m_acc_dir = exp_dir.pop_front();
          end
        end
      end
      if (new_frame && !m_nf_q) m_fpend = 1;
      m_nf_q = new_frame;
      if (m_fpend && !m_infl) begin
        m_rd = 0; m_wr = 0; m_buf = ~m_buf; m_fpend = 0;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input bit rd, input bit wr);
    rd_line_req = rd;
    wr_line_req = wr;
    tick();
    rd_line_req = 1'b0;
    wr_line_req = 1'b0;
  endtask

  task automatic hs(output logic d, output logic [31:0] a);
    int n = 0;
    while (!(dma.dma_cmd_valid && dma.dma_cmd_ready) && n < 100) begin
      tick();
      n++;
    end
    chk("handshake_timeout", 32'(n < 100), 32'd1);
    d = dma.dma_cmd_dir;
    a = dma.dma_cmd_addr;
    tick();
  endtask

  task automatic xfer(input bit err, output logic d, output logic [31:0] a);
    hs(d, a);
    dma.dma_done = !err;
    dma.dma_err  = err;
    tick();
    dma.dma_done = 1'b0;
    dma.dma_err  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time budget exceeded, got t=%0t expected finish", $time);
    $fatal(1);
  end

  logic        d, wd;
  logic [31:0] a, wa, ra;

  initial begin
    dma.dma_cmd_ready = 1'b0;
    dma.dma_done      = 1'b0;
    dma.dma_err       = 1'b0;
    do_reset();

    chk("rst_valid",   dma.dma_cmd_valid, 0);
    chk("rst_dir",     dma.dma_cmd_dir,   0);
    chk("rst_addr",    dma.dma_cmd_addr,  0);
    chk("rst_len",     dma.dma_cmd_len,   0);
    chk("rst_buf_sel", buf_sel,           0);
    chk("rst_rd_line", rd_line,           0);
    chk("rst_wr_line", wr_line,           0);
    chk("rst_busy",    busy,              0);
    chk("rst_overrun", overrun,           0);

    // single read, ready tied high
    dma.dma_cmd_ready = 1'b1;
    exp_dir.push_back(1'b0);
    pulse(1, 0);
    chk("t1_valid_t0", dma.dma_cmd_valid, 0);
    tick();
    chk("t1_valid_t1", dma.dma_cmd_valid, 1);
    chk("t1_dir",      dma.dma_cmd_dir,   0);
    chk("t1_addr",     dma.dma_cmd_addr,  32'h1000_0000);
    chk("t1_len",      dma.dma_cmd_len,   256);
    xfer(0, d, a);
    chk("t1_rd_line",  rd_line, 1);
    chk("t1_busy",     busy,    0);

    // simultaneous write+read: write first, one idle cycle between
    exp_dir.push_back(1'b1);
    exp_dir.push_back(1'b0);
    pulse(1, 1);
    xfer(0, d, a);
    chk("t2_wr_dir",   d, 1);
    chk("t2_wr_addr",  a, 32'h1002_0000);
    chk("t2_gap",      dma.dma_cmd_valid, 0);
    tick();
    chk("t2_rd_valid", dma.dma_cmd_valid, 1);
    chk("t2_rd_dir",   dma.dma_cmd_dir,   0);
    xfer(0, d, a);
    chk("t2_rd_addr",  a, 32'h1000_0100);
    chk("t2_rd_line",  rd_line, 2);
    chk("t2_wr_line",  wr_line, 1);

    // overrun: two reads while a write sits unaccepted
    do_reset();
    dma.dma_cmd_ready = 1'b0;
    exp_dir.push_back(1'b1);
    exp_dir.push_back(1'b0);
    pulse(0, 1);
    tick();
    tick();
    pulse(1, 0);
    tick();
    tick();
    pulse(1, 0);
    chk("t3_overrun", overrun, 1);
    dma.dma_cmd_ready = 1'b1;
    xfer(0, d, a);
    chk("t3_wr_addr", a, 32'h1002_0000);
    xfer(0, d, a);
    chk("t3_rd_addr", a, 32'h1000_0000);
    repeat (6) tick();
    chk("t3_no_second_rd", dma.dma_cmd_valid, 0);
    chk("t3_rd_line",      rd_line, 1);

    // full frame window, then one extra read request
    do_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      exp_dir.push_back(1'b1);
      exp_dir.push_back(1'b0);
      pulse(1, 1);
      xfer(0, wd, wa);
      xfer(0, d, ra);
    end
    chk("t4_last_rd_addr", ra, 32'h1000_7F00);
    chk("t4_last_wr_addr", wa, 32'h1002_7F00);
    chk("t4_rd_line",      rd_line, 128);
    chk("t4_wr_line",      wr_line, 128);
    pulse(1, 0);
    repeat (5) tick();
    chk("t4_extra_valid",   dma.dma_cmd_valid, 0);
    chk("t4_extra_busy",    busy,    0);
    chk("t4_extra_overrun", overrun, 0);
    chk("t4_extra_rd_line", rd_line, 128);

    // frame edge during WAIT_DONE with a read pending
    do_reset();
    exp_dir.push_back(1'b0);
    pulse(1, 0);
    hs(d, a);
    pulse(1, 0);
    new_frame = 1'b1;
    tick();
    tick();
    dma.dma_done = 1'b1;
    tick();
    dma.dma_done = 1'b0;
    chk("t5_rd_line_before_apply", rd_line, 1);
    tick();
    tick();
    chk("t5_buf_sel", buf_sel, 1);
    chk("t5_rd_line", rd_line, 0);
    chk("t5_wr_line", wr_line, 0);
    chk("t5_no_cmd",  dma.dma_cmd_valid, 0);
    chk("t5_overrun", overrun, 0);
    exp_dir.push_back(1'b0);
    pulse(1, 0);
    xfer(0, d, a);
    chk("t5_rd_dir",  d, 0);
    chk("t5_rd_addr", a, 32'h1002_0000);

    // DMA error on a write, then reissue the same line
    exp_dir.push_back(1'b1);
    pulse(0, 1);
    xfer(0, d, a);
    chk("t6_wr0_addr", a, 32'h1000_0000);
    exp_dir.push_back(1'b1);
    pulse(0, 1);
    xfer(1, d, a);
    chk("t6_err_addr", a, 32'h1000_0100);
    chk("t6_fault",    dma_fault, 1);
    chk("t6_wr_line",  wr_line,   1);
    chk("t6_busy",     busy,      0);
    exp_dir.push_back(1'b1);
    pulse(0, 1);
    xfer(0, d, a);
    chk("t6_retry_addr", a, 32'h1000_0100);
    chk("t6_wr_line2",   wr_line, 2);

    // reset mid-transfer; late done must be ignored
    new_frame = 1'b0;
    tick();
    exp_dir.push_back(1'b0);
    pulse(1, 0);
    hs(d, a);
    do_reset();
    dma.dma_done = 1'b1;
    tick();
    dma.dma_done = 1'b0;
    tick();
    chk("t7_rd_line", rd_line,   0);
    chk("t7_busy",    busy,      0);
    chk("t7_fault",   dma_fault, 0);
    chk("t7_buf_sel", buf_sel,   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dvs_line_dma_sched.md
# dvs_line_dma_sched

Sequences DDR line transfers for the DVS frame-difference pipeline. Accepts per-line read/write request pulses from the pixel datapath and issues one command at a time to the PS CDMA: read reference line DDR->BRAM, or write result line BRAM->DDR. Owns line counters, ping-pong frame-buffer selection, overrun and error flags. Sits between the camera-domain datapath and the PS DMA command interface, all in the pclk domain.

## Interface
- BASE_A, 32'h1000_0000, DDR base address of frame buffer A
- BASE_B, 32'h1002_0000, DDR base address of frame buffer B
- LINE_BYTES, 256, bytes per line transfer (64 packed 32-bit BRAM words)
- NUM_LINES, 128, lines per frame window; valid range 2..255
- pclk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high reset
- new_frame  in  1  frame level from camera; a rising edge starts a frame
- rd_line_req  in  1  one-cycle pulse: fetch next reference line
- wr_line_req  in  1  one-cycle pulse: store current result line
- dma_cmd_valid  out  1  command valid
- dma_cmd_ready  in  1  PS accepts command when valid && ready
- dma_cmd_dir  out  1  0 = DDR->BRAM (read), 1 = BRAM->DDR (write)
- dma_cmd_addr  out  32  DDR byte address
- dma_cmd_len  out  16  transfer length in bytes, always LINE_BYTES
- dma_done  in  1  one-cycle pulse: accepted command finished
- dma_err  in  1  one-cycle pulse: accepted command failed
- buf_sel  out  1  current read buffer (0 = A, 1 = B); writes target the other buffer
- rd_line  out  8  reference lines completed this frame
- wr_line  out  8  result lines completed this frame
- busy  out  1  high in ISSUE or WAIT_DONE
- overrun  out  1  sticky: request arrived while same-type request already pending
- dma_fault  out  1  sticky: dma_err seen

## Operation
- Reset values: all outputs 0, FSM IDLE, pending flags 0, frame_pend 0.
- Pending flags rd_pend and wr_pend, one-deep each. A pulse sets its flag. Pulse while the flag is set: request dropped, overrun set.
- Pulse when its line counter == NUM_LINES: ignored; no flag, no overrun.
- FSM IDLE: if frame_pend, apply frame start and stay IDLE that cycle. Else if wr_pend, load write command. Else if rd_pend, load read command. Loading clears the flag and moves to ISSUE. Write wins over read: the result line must leave BRAM before the next reference overwrites it.
- FSM ISSUE: dma_cmd_valid=1, with dir/addr/len held stable. On valid && ready, go to WAIT_DONE.
- FSM WAIT_DONE: on dma_done, increment the matching counter and go to IDLE. On dma_err, set dma_fault, leave counters unchanged, go to IDLE; no retry. If both pulse together, err wins.
- dma_done/dma_err outside WAIT_DONE: ignored.
- Read address: (buf_sel ? BASE_B : BASE_A) + rd_line*LINE_BYTES.
- Write address: (buf_sel ? BASE_A : BASE_B) + wr_line*LINE_BYTES.
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Frame edge (new_frame 0->1, registered detect): clear rd_pend/wr_pend on that same edge and set frame_pend.
- A request pulse sampled in the same cycle as the edge, or later, is kept and belongs to the new frame.
- Frame start applies only in IDLE, so any in-flight transfer completes first: rd_line=0, wr_line=0, buf_sel toggles, frame_pend clears.
- overrun and dma_fault clear only on reset.

## Timing
- Request pulse sampled at edge t sets its flag at t.
- If IDLE with no frame_pend, the command loads at t+1 and dma_cmd_valid is high from t+1 to handshake. Minimum latency is 1 cycle.
- Handshake at edge h -> WAIT_DONE at h, valid low after h.
- dma_done at edge d -> counter updated and IDLE at d. The next pending command can be valid from d+1, giving 1 idle cycle between commands.
- Frame edge seen at edge f while IDLE -> frame applied at f+1, and the earliest new command is valid at f+2.
- Reset asserted mid-transfer: everything returns to reset values on that edge, and later dma_done is ignored. Software must quiesce the CDMA before releasing reset.

## Test plan
- Reset, single rd_line_req with ready tied high -> valid 1 cycle after the pulse, dir=0, addr=BASE_A, len=256; after dma_done, rd_line=1.
- wr_line_req and rd_line_req in the same cycle -> write issued first to BASE_B+0; read issued only after write done, 1 idle cycle between them.
- Two rd_line_req 3 cycles apart with ready held low -> overrun=1, only one read command issued, rd_line=1 after done.
- 128 read+write pairs, then one extra rd_line_req -> last read addr BASE_A+127*256 (BASE_A+0x7F00); extra pulse produces no command and no overrun.
- new_frame rises during WAIT_DONE with rd_pend set -> rd_pend cleared, transfer completes, then buf_sel=1 and counters 0; next read targets BASE_B+0.
- dma_err in WAIT_DONE of a write -> dma_fault=1, wr_line unchanged, FSM IDLE; next write reissues the same address.
